pp_stage_skid: RTL and testbench

- Parametrised, handshaked pipeline stage register. Successor to the plain stall/flush stage registers.
- Adds valid/ready flow control, a two-entry skid buffer so in_ready is a registered signal, flush with NOP injection, and a discard counter.
- Instantiated between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Lets downstream back-pressure reach upstream without a combinational ready path.

---
 rtl/pp_stage_skid.sv | 92 +++++++++
 tb/tb_pp_stage_skid.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pp_stage_skid.sv
// Handshaked pipeline stage register: main register plus one skid entry, so in_ready is registered.
// Latency one cycle; downstream back-pressure fills the skid entry, then drops in_ready; flush kills both entries.
module pp_stage_skid #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] discard_cnt
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic accept;
  logic consume;

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_data    = main_data_q;
  assign discard_cnt = cnt_q;

  assign accept  = in_valid & ~skid_valid_q;
  assign consume = main_valid_q & out_ready & ~stall;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    cnt_d        = cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_VALUE;
      skid_valid_d = 1'b0;
      // Count only flushes that actually killed something; saturate rather than wrap.
      if ((main_valid_q | skid_valid_q) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (skid_valid_q) begin
      if (consume) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (consume) begin
        if (accept) begin
          main_data_d = in_data;
        end else begin
          main_valid_d = 1'b0;
          main_data_d  = NOP_VALUE;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VALUE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VALUE;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pp_stage_skid.sv
// Bench for pp_stage_skid: directed vector table, then random traffic against a queue model.
module tb_pp_stage_skid;

  localparam int          W   = 16;
  localparam int          CW  = 2;
  localparam logic [15:0] NOP = 16'hBEEF;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          stall;
  logic          flush;
  logic [CW-1:0] discard_cnt;

  int checks;
  int failures;

  pp_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .stall      (stall),
    .flush      (flush),
    .discard_cnt(discard_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rn;
    logic        iv;
    logic [15:0] id;
    logic        o;
    logic        s;
    logic        f;
    logic        ev;
    logic [15:0] ed;
    logic        er;
    logic [1:0]  ec;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic rn, input logic iv, input logic [15:0] id,
                     input logic o, input logic s, input logic f,
                     input logic ev, input logic [15:0] ed, input logic er, input int ec);
    vec_t t;
    t.rn = rn; t.iv = iv; t.id = id; t.o = o; t.s = s; t.f = f;
    t.ev = ev; t.ed = ed; t.er = er; t.ec = 2'(ec);
    vec.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic iv, input logic [15:0] id,
                       input logic o, input logic s, input logic f);
    reset = rn; in_valid = iv; in_data = id; out_ready = o; stall = s; flush = f;
  endtask

  logic [15:0] mq[$];
  int          mcnt;

  initial begin
    checks = 0;
    failures = 0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset state
    add(0, 0, 0, 0, 0, 0, 0, NOP, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, NOP, 1, 0);
    // Streaming, no bubbles
    for (int k = 1; k <= 10; k++) add(1, 1, 16'(k), 1, 0, 0, 1, 16'(k), 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, NOP, 1, 0);
    // Back-pressure into the skid entry
    add(1, 1, 16'hA, 0, 0, 0, 1, 16'hA, 1, 0);
    add(1, 1, 16'hB, 0, 0, 0, 1, 16'hA, 0, 0);
    add(1, 1, 16'hC, 0, 0, 0, 1, 16'hA, 0, 0);
    add(1, 1, 16'hC, 1, 0, 0, 1, 16'hB, 1, 0);
    add(1, 1, 16'hC, 1, 0, 0, 1, 16'hC, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, NOP, 1, 0);
    // Stall overrides out_ready
    add(1, 1, 16'h55, 1, 0, 0, 1, 16'h55, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 1, 1, 0, 1, 16'h55, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, NOP, 1, 0);
    // Flush with simultaneous input, then flush while empty
    add(1, 1, 16'h11, 0, 0, 0, 1, 16'h11, 1, 0);
    add(1, 1, 16'h22, 0, 0, 0, 1, 16'h11, 0, 0);
    add(1, 1, 16'h77, 0, 0, 1, 0, NOP, 1, 1);
    add(1, 1, 16'h66, 0, 0, 1, 0, NOP, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, NOP, 1, 1);
    // Counter saturation: flushes 2..5 of a single held entry
    for (int c = 2; c <= 5; c++) begin
      add(1, 1, 16'(16'h30 + c), 0, 0, 0, 1, 16'(16'h30 + c), 1, (c - 1 > 3) ? 3 : c - 1);
      add(1, 0, 0, 1, 0, 1, 0, NOP, 1, (c > 3) ? 3 : c);
    end
    // Reset mid-operation with both entries full
    add(1, 1, 16'h11, 0, 0, 0, 1, 16'h11, 1, 3);
    add(1, 1, 16'h22, 0, 0, 0, 1, 16'h11, 0, 3);
    add(0, 1, 16'h99, 1, 0, 1, 0, NOP, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, NOP, 1, 0);

    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].rn, vec[i].iv, vec[i].id, vec[i].o, vec[i].s, vec[i].f);
      @(posedge clock);
      #1;
      chk("vec_out_valid", i, 32'(out_valid), 32'(vec[i].ev));
      chk("vec_out_data", i, 32'(out_data), 32'(vec[i].ed));
      chk("vec_in_ready", i, 32'(in_ready), 32'(vec[i].er));
      chk("vec_discard_cnt", i, 32'(discard_cnt), 32'(vec[i].ec));
    end

    // Random traffic against an occupancy-queue model
    mq.delete();
    mcnt = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 3000; i++) begin
      logic r, v, o, s, f, cons, acc;
      logic [15:0] d;
      r = ($urandom_range(0, 199) != 0);
      f = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 4) == 0);
      d = 16'($urandom);
      drive(r, v, d, o, s, f);
      if (!r) begin
        mq.delete();
        mcnt = 0;
      end else if (f) begin
        if (mq.size() > 0 && mcnt < CNT_MAX) mcnt++;
        mq.delete();
      end else begin
        cons = (mq.size() > 0) && o && !s;
        acc  = v && (mq.size() < 2);
        if (cons) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
      @(posedge clock);
      #1;
      chk("rnd_out_valid", i, 32'(out_valid), 32'(mq.size() > 0));
      chk("rnd_out_data", i, 32'(out_data), 32'((mq.size() > 0) ? mq[0] : NOP));
      chk("rnd_in_ready", i, 32'(in_ready), 32'(mq.size() < 2));
      chk("rnd_discard_cnt", i, 32'(discard_cnt), 32'(mcnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
